// File: rtl/mu0_boot_ctrl.sv
// ----------------------------------------------------------------------------
// mu0_boot_ctrl
//
// Boot sequencer and memory-port owner for the Mu0 core. The core is held in
// reset while a program image is streamed into the shared memory over a
// valid/ready loader port. Once the image is complete, the core is released.
// The block muxes the memory control and address lines between the loader
// and the core. It declares a halt after the core stops requesting memory.
//
// Optional feature: define MU0_BOOT_CHKSUM_EN to build the load checksum
// (a 16-bit modular sum of the loaded words). Without it, o_chksum is tied to 0.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   i_start           single-cycle load request (honoured in IDLE/HALTED)
//   i_ld_len          image length in words, 1..2^ADDR (0 ignored)
//   i_ld_valid        loader word valid
//   i_ld_data         loader word
//   o_ld_ready        high for every LOAD cycle
//   o_cpu_rst         reset to the Mu0 core (IDLE/LOAD)
//   i_cpu_mem_rq      core memory request
//   i_cpu_rnw         core read/not-write
//   i_cpu_addr        core address
//   o_mem_rq          memory request (loader write or core pass-through)
//   o_mem_rnw         memory read/not-write
//   o_mem_addr        memory address
//   o_mem_wdata       loader write data
//   o_mem_wdata_oe    drives o_mem_wdata onto the shared databus
//   o_busy            LOAD state
//   o_halted          HALTED state
//   o_wcount          words written in the current/last load
//   o_chksum          load checksum
// ----------------------------------------------------------------------------
module mu0_boot_ctrl #(
    parameter int ADDR     = 12,
    parameter int DATA     = 16,
    parameter int HALT_CYC = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_start,
    input  logic [ADDR:0]   i_ld_len,
    input  logic            i_ld_valid,
    input  logic [DATA-1:0] i_ld_data,
    output logic            o_ld_ready,
    output logic            o_cpu_rst,
    input  logic            i_cpu_mem_rq,
    input  logic            i_cpu_rnw,
    input  logic [ADDR-1:0] i_cpu_addr,
    output logic            o_mem_rq,
    output logic            o_mem_rnw,
    output logic [ADDR-1:0] o_mem_addr,
    output logic [DATA-1:0] o_mem_wdata,
    output logic            o_mem_wdata_oe,
    output logic            o_busy,
    output logic            o_halted,
    output logic [ADDR:0]   o_wcount,
    output logic [DATA-1:0] o_chksum
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_RUN    = 2'd2;
    localparam logic [1:0] S_HALTED = 2'd3;

    localparam int              HCW       = $clog2(HALT_CYC + 1);
    localparam logic [HCW-1:0]  HALT_MAX  = HCW'(HALT_CYC);
    localparam logic [HCW-1:0]  HALT_LAST = HCW'(HALT_CYC - 1);
    localparam logic [ADDR:0]   ONE       = (ADDR+1)'(1);

    logic [1:0]     r_state;
    logic [ADDR:0]  r_len;
    logic [ADDR:0]  r_wcount;
    logic [HCW-1:0] r_halt_cnt;

    logic w_accept;
    logic w_start_ok;
    logic w_last;

    assign w_accept   = (r_state == S_LOAD) && i_ld_valid;
    assign w_start_ok = i_start && (i_ld_len != '0) &&
                        ((r_state == S_IDLE) || (r_state == S_HALTED));
    assign w_last     = (r_wcount == (r_len - ONE));

    // Main sequencer. The wcount guard enforces saturation at the latched length.
    // The final accepted word moves the FSM to RUN on the same edge that
    // the memory samples the write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_len    <= '0;
            r_wcount <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_HALTED: begin
                    if (w_start_ok) begin
                        r_state  <= S_LOAD;
                        r_len    <= i_ld_len;
                        r_wcount <= '0;
                    end
                end
                S_LOAD: begin
                    if (w_accept && (r_wcount != r_len)) begin
                        r_wcount <= r_wcount + ONE;
                        if (w_last)
                            r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (!i_cpu_mem_rq && (r_halt_cnt == HALT_LAST))
                        r_state <= S_HALTED;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // The halt counter only counts while the core runs.
    // It saturates at HALT_CYC, so a long idle stretch cannot wrap it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_halt_cnt <= '0;
        end else if (w_start_ok) begin
            r_halt_cnt <= '0;
        end else if (r_state == S_RUN) begin
            if (i_cpu_mem_rq)
                r_halt_cnt <= '0;
            else if (r_halt_cnt != HALT_MAX)
                r_halt_cnt <= r_halt_cnt + 1'b1;
        end
    end

`ifdef MU0_BOOT_CHKSUM_EN
    logic [DATA-1:0] r_chksum;

    // The checksum is a running modular sum of the accepted words.
    // It holds after LOAD, so the host can read it while the core runs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_chksum <= '0;
        else if (w_start_ok)
            r_chksum <= '0;
        else if (w_accept && (r_wcount != r_len))
            r_chksum <= r_chksum + i_ld_data;
    end

    assign o_chksum = r_chksum;
`else
    assign o_chksum = '0;
`endif

    // Memory port mux. The loader owns the port in LOAD and the core owns it
    // in RUN/HALTED; otherwise the port is parked idle.
    always_comb begin
        o_mem_rq       = 1'b0;
        o_mem_rnw      = 1'b1;
        o_mem_addr     = '0;
        o_mem_wdata    = '0;
        o_mem_wdata_oe = 1'b0;
        case (r_state)
            S_LOAD: begin
                if (w_accept) begin
                    o_mem_rq       = 1'b1;
                    o_mem_rnw      = 1'b0;
                    o_mem_addr     = r_wcount[ADDR-1:0];
                    o_mem_wdata    = i_ld_data;
                    o_mem_wdata_oe = 1'b1;
                end
            end
            S_RUN, S_HALTED: begin
                o_mem_rq   = i_cpu_mem_rq;
                o_mem_rnw  = i_cpu_rnw;
                o_mem_addr = i_cpu_addr;
            end
            default: ;
        endcase
    end

    assign o_cpu_rst  = (r_state == S_IDLE) || (r_state == S_LOAD);
    assign o_ld_ready = (r_state == S_LOAD);
    assign o_busy     = (r_state == S_LOAD);
    assign o_halted   = (r_state == S_HALTED);
    assign o_wcount   = r_wcount;

endmodule

// File: tb/tb_mu0_boot_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mu0_boot_ctrl
//
// Self-checking bench for mu0_boot_ctrl.
// The stimulus pushes each expected memory write into a queue.
// A monitor on the falling edge pops and compares each write the DUT drives.
// When no write is driven, the monitor checks either core pass-through or an
// idle memory port.
// ----------------------------------------------------------------------------
module tb_mu0_boot_ctrl;

    localparam int ADDR     = 12;
    localparam int DATA     = 16;
    localparam int HALT_CYC = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [ADDR:0]   ldLen = '0;
    logic            ldValid = 1'b0;
    logic [DATA-1:0] ldData = '0;
    logic            ldReady;
    logic            cpuRst;
    logic            cpuMemRq = 1'b1;
    logic            cpuRnw = 1'b1;
    logic [ADDR-1:0] cpuAddr = '0;
    logic            memRq;
    logic            memRnw;
    logic [ADDR-1:0] memAddr;
    logic [DATA-1:0] memWdata;
    logic            memWdataOe;
    logic            busy;
    logic            halted;
    logic [ADDR:0]   wcount;
    logic [DATA-1:0] chksum;

    typedef struct packed {
        logic [ADDR-1:0] addr;
        logic [DATA-1:0] data;
    } wr_t;

    wr_t             expQ[$];
    int              testsRun = 0;
    int              testsFailed = 0;
    bit              expPass = 1'b0;
    logic [DATA-1:0] expSum = '0;

    mu0_boot_ctrl #(.ADDR(ADDR), .DATA(DATA), .HALT_CYC(HALT_CYC)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_start       (start),
        .i_ld_len      (ldLen),
        .i_ld_valid    (ldValid),
        .i_ld_data     (ldData),
        .o_ld_ready    (ldReady),
        .o_cpu_rst     (cpuRst),
        .i_cpu_mem_rq  (cpuMemRq),
        .i_cpu_rnw     (cpuRnw),
        .i_cpu_addr    (cpuAddr),
        .o_mem_rq      (memRq),
        .o_mem_rnw     (memRnw),
        .o_mem_addr    (memAddr),
        .o_mem_wdata   (memWdata),
        .o_mem_wdata_oe(memWdataOe),
        .o_busy        (busy),
        .o_halted      (halted),
        .o_wcount      (wcount),
        .o_chksum      (chksum)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Sets the inputs for one cycle. If a write is expected, it is queued
    // and added to the checksum model.
    task automatic applyStimulus(input logic s, input logic [ADDR:0] len,
                                 input logic v, input logic [DATA-1:0] d,
                                 input bit push, input logic [ADDR-1:0] a);
        wr_t e;
        start   = s;
        ldLen   = len;
        ldValid = v;
        ldData  = d;
        if (push) begin
            e.addr = a;
            e.data = d;
            expQ.push_back(e);
            expSum = expSum + d;
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DATA-1:0] expChk();
`ifdef MU0_BOOT_CHKSUM_EN
        return expSum;
`else
        return '0;
`endif
    endfunction

    // Monitor process: compares every write against the queue.
    // Non-write cycles check pass-through or an idle port.
    always @(negedge clk) begin
        if (!rst) begin
            if (memWdataOe) begin
                if (expQ.size() == 0) begin
                    testsRun++;
                    testsFailed++;
                    $display("[TB] FAIL spurious_write: got addr 0x%0h data 0x%0h, expected no write",
                             memAddr, memWdata);
                end else begin
                    wr_t e;
                    e = expQ.pop_front();
                    checkOutput("wr_addr", 32'(memAddr), 32'(e.addr));
                    checkOutput("wr_data", 32'(memWdata), 32'(e.data));
                    checkOutput("wr_rq", 32'(memRq), 32'd1);
                    checkOutput("wr_rnw", 32'(memRnw), 32'd0);
                end
            end else if (expPass) begin
                checkOutput("pass_rq", 32'(memRq), 32'(cpuMemRq));
                checkOutput("pass_rnw", 32'(memRnw), 32'(cpuRnw));
                checkOutput("pass_addr", 32'(memAddr), 32'(cpuAddr));
            end else begin
                checkOutput("idle_rq", 32'(memRq), 32'd0);
                checkOutput("idle_rnw", 32'(memRnw), 32'd1);
                checkOutput("idle_addr", 32'(memAddr), 32'd0);
                checkOutput("idle_wdata", 32'(memWdata), 32'd0);
            end
        end
    end

    logic [DATA-1:0] words3[3] = '{16'h0005, 16'h2006, 16'h7000};
    int              haltPat[5] = '{1, 0, 1, 0, 0};
    int              gapPat[4] = '{1, 0, 0, 1};
    logic [DATA-1:0] gapData[4] = '{16'h1111, 16'hBEEF, 16'hBEEF, 16'h2222};

    initial begin : stim
        int k;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_cpu_rst", 32'(cpuRst), 32'd1);
        checkOutput("rst_ld_ready", 32'(ldReady), 32'd0);
        checkOutput("rst_mem_rq", 32'(memRq), 32'd0);
        checkOutput("rst_mem_rnw", 32'(memRnw), 32'd1);
        checkOutput("rst_mem_addr", 32'(memAddr), 32'd0);
        checkOutput("rst_mem_wdata", 32'(memWdata), 32'd0);
        checkOutput("rst_wdata_oe", 32'(memWdataOe), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_halted", 32'(halted), 32'd0);
        checkOutput("rst_wcount", 32'(wcount), 32'd0);
        checkOutput("rst_chksum", 32'(chksum), 32'd0);
        stepCycle();
        rst = 1'b0;

        // Three-word back-to-back load.
        applyStimulus(1'b1, 13'd3, 1'b0, '0, 1'b0, '0);
        @(negedge clk);
        checkOutput("t1_ready_before", 32'(ldReady), 32'd0);
        stepCycle();
        expSum = '0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 13'd3, 1'b1, words3[i], 1'b1, ADDR'(i));
            @(negedge clk);
            checkOutput("t1_ld_ready", 32'(ldReady), 32'd1);
            checkOutput("t1_cpu_rst_load", 32'(cpuRst), 32'd1);
            checkOutput("t1_busy", 32'(busy), 32'd1);
            stepCycle();
        end
        expPass = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0);
        cpuAddr = 12'h123;
        @(negedge clk);
        checkOutput("t1_cpu_rst_run", 32'(cpuRst), 32'd0);
        checkOutput("t1_wcount", 32'(wcount), 32'd3);
        checkOutput("t1_chksum", 32'(chksum), 32'(expChk()));
        checkOutput("t1_ld_ready_run", 32'(ldReady), 32'd0);
        stepCycle();

        // A start request and a stray ld_valid during RUN are ignored.
        applyStimulus(1'b1, 13'd2, 1'b1, 16'hDEAD, 1'b0, '0);
        cpuRnw = 1'b0;
        cpuAddr = 12'h0AA;
        stepCycle();
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0);
        @(negedge clk);
        checkOutput("t5_run_busy", 32'(busy), 32'd0);
        checkOutput("t5_run_cpu_rst", 32'(cpuRst), 32'd0);
        checkOutput("t5_run_wcount", 32'(wcount), 32'd3);
        stepCycle();

        // Halt detection with request pattern 1,0,1,0,0.
        for (int i = 0; i < 5; i++) begin
            cpuMemRq = haltPat[i][0];
            cpuRnw = i[0];
            cpuAddr = ADDR'(12'h200 + i);
            @(negedge clk);
            checkOutput("t3_halted_pre", 32'(halted), 32'd0);
            stepCycle();
        end
        cpuMemRq = 1'b1;
        @(negedge clk);
        checkOutput("t3_halted", 32'(halted), 32'd1);
        checkOutput("t3_cpu_rst", 32'(cpuRst), 32'd0);

        // Gapped two-word load from HALTED.
        applyStimulus(1'b1, 13'd2, 1'b0, '0, 1'b0, '0);
        stepCycle();
        expPass = 1'b0;
        expSum = '0;
        k = 0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 13'd2, gapPat[i][0], gapData[i], gapPat[i] != 0, ADDR'(k));
            @(negedge clk);
            checkOutput("t2_ld_ready", 32'(ldReady), 32'd1);
            checkOutput("t2_halted", 32'(halted), 32'd0);
            stepCycle();
            k = k + gapPat[i];
        end
        expPass = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0);
        @(negedge clk);
        checkOutput("t2_wcount", 32'(wcount), 32'd2);
        checkOutput("t2_cpu_rst", 32'(cpuRst), 32'd0);
        checkOutput("t2_chksum", 32'(chksum), 32'(expChk()));

        // Reset in the middle of a four-word load.
        cpuMemRq = 1'b0;
        stepCycle();
        stepCycle();
        cpuMemRq = 1'b1;
        @(negedge clk);
        checkOutput("t4_halted", 32'(halted), 32'd1);
        applyStimulus(1'b1, 13'd4, 1'b0, '0, 1'b0, '0);
        stepCycle();
        expPass = 1'b0;
        expSum = '0;
        applyStimulus(1'b0, 13'd4, 1'b1, 16'h4444, 1'b1, 12'd0);
        stepCycle();
        applyStimulus(1'b0, 13'd4, 1'b1, 16'h5555, 1'b1, 12'd1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("t4_cpu_rst", 32'(cpuRst), 32'd1);
        checkOutput("t4_busy", 32'(busy), 32'd0);
        checkOutput("t4_wcount", 32'(wcount), 32'd0);
        checkOutput("t4_mem_rq", 32'(memRq), 32'd0);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0);
        stepCycle();
        rst = 1'b0;
        expSum = '0;
        @(negedge clk);
        checkOutput("t4_idle_cpu_rst", 32'(cpuRst), 32'd1);
        checkOutput("t4_idle_chksum", 32'(chksum), 32'd0);
        applyStimulus(1'b1, 13'd1, 1'b0, '0, 1'b0, '0);
        stepCycle();
        applyStimulus(1'b0, 13'd1, 1'b1, 16'hABCD, 1'b1, 12'd0);
        stepCycle();
        expPass = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0);
        @(negedge clk);
        checkOutput("t4_len1_wcount", 32'(wcount), 32'd1);
        checkOutput("t4_len1_cpu_rst", 32'(cpuRst), 32'd0);
        checkOutput("t4_len1_chksum", 32'(chksum), 32'(expChk()));

        // A zero-length start and a stray ld_valid in HALTED are ignored.
        cpuMemRq = 1'b0;
        stepCycle();
        stepCycle();
        cpuMemRq = 1'b1;
        applyStimulus(1'b1, 13'd0, 1'b1, 16'h7777, 1'b0, '0);
        stepCycle();
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0);
        @(negedge clk);
        checkOutput("t5_len0_halted", 32'(halted), 32'd1);
        checkOutput("t5_len0_busy", 32'(busy), 32'd0);
        checkOutput("t5_len0_wcount", 32'(wcount), 32'd1);

        // Full-memory load of 4096 words from HALTED.
        applyStimulus(1'b1, 13'd4096, 1'b0, '0, 1'b0, '0);
        stepCycle();
        expPass = 1'b0;
        expSum = '0;
        for (int i = 0; i < 4096; i++) begin
            applyStimulus(1'b0, 13'd4096, 1'b1, DATA'(i * 7 + 3), 1'b1, ADDR'(i));
            @(negedge clk);
            if (i == 0 || i == 4095)
                checkOutput("t6_ld_ready", 32'(ldReady), 32'd1);
            stepCycle();
        end
        expPass = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0);
        @(negedge clk);
        checkOutput("t6_halted", 32'(halted), 32'd0);
        checkOutput("t6_cpu_rst", 32'(cpuRst), 32'd0);
        checkOutput("t6_wcount", 32'(wcount), 32'd4096);
        checkOutput("t6_busy", 32'(busy), 32'd0);
        checkOutput("t6_chksum", 32'(chksum), 32'(expChk()));
        stepCycle();

        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
